// File: rtl/i2c_apb_fifo_regs.sv
// i2c_apb_fifo_regs: APB slave register front end for the I2C byte engine.
// Provides TX/RX FIFOs (pointers plus a count, first-word-fall-through),
// programmable APB wait states, a transfer command block and sticky status.
// Optional build macro: I2C_APB_IRQ_EN adds a registered irq output.
module i2c_apb_fifo_regs #(
    parameter int             ADDR_W       = 8,
    parameter int             DATA_W       = 8,
    parameter int             TX_DEPTH     = 16,
    parameter int             RX_DEPTH     = 16,
    parameter int             WAIT_STATES  = 0,
    parameter logic [DATA_W-1:0] PRESCALE_RST = 8'd50
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSELx,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic              PREADY,
    output logic [DATA_W-1:0] PRDATA,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_pop,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_push,
    output logic              cmd_start,
    output logic              cmd_rw,
    output logic [6:0]        cmd_addr,
    output logic [DATA_W-1:0] cmd_count,
    output logic [DATA_W-1:0] prescale,
    input  logic              core_busy,
    input  logic              core_done,
    input  logic              core_nack
`ifdef I2C_APB_IRQ_EN
    ,
    output logic              irq
`endif
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW+1)'(TX_DEPTH);
    localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW+1)'(RX_DEPTH);
    localparam logic [2:0]     WS          = 3'(WAIT_STATES);

    // Register state
    logic [2:0]        wait_cnt_q, wait_cnt_d;
    logic              en_q, en_d, rw_q, rw_d, irq_en_q, irq_en_d;
    logic [6:0]        addr_q, addr_d;
    logic [DATA_W-1:0] count_q, count_d, prescale_q, prescale_d;
    logic              done_q, done_d, nack_q, nack_d, ovf_q, ovf_d;
    logic              cmd_start_q, cmd_start_d, cmd_rw_q, cmd_rw_d;
    logic [6:0]        cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_count_q, cmd_count_d;
    logic [TX_AW-1:0]  tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [TX_AW:0]    tx_cnt_q, tx_cnt_d;
    logic [RX_AW-1:0]  rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [RX_AW:0]    rx_cnt_q, rx_cnt_d;
    logic [DATA_W-1:0] tx_mem [TX_DEPTH];
    logic [DATA_W-1:0] rx_mem [RX_DEPTH];

    // Bus decode: side effects happen only on the completing access cycle
    logic access, commit, wr_commit, rd_commit, addr_ok;
    logic [2:0] reg_sel;
    logic sel_ctrl, sel_addr, sel_count, sel_txdata, sel_rxdata, sel_status, sel_prescale;
    logic tx_full, tx_empty, rx_full, rx_empty, busy;
    logic tx_do_push, tx_do_pop, rx_do_push, rx_do_pop, ovf_set, fire;
    logic [DATA_W-1:0] rdata;
    logic unused_paddr;

    assign unused_paddr = ^PADDR[1:0];
    assign access     = PSELx & PENABLE;
    assign PREADY     = access & (wait_cnt_q == WS);
    assign commit     = PREADY;
    assign wr_commit  = commit & PWRITE;
    assign rd_commit  = commit & ~PWRITE;
    assign addr_ok    = (PADDR[ADDR_W-1:5] == '0);
    assign reg_sel    = PADDR[4:2];
    assign sel_ctrl     = addr_ok && (reg_sel == 3'd0);
    assign sel_addr     = addr_ok && (reg_sel == 3'd1);
    assign sel_count    = addr_ok && (reg_sel == 3'd2);
    assign sel_txdata   = addr_ok && (reg_sel == 3'd3);
    assign sel_rxdata   = addr_ok && (reg_sel == 3'd4);
    assign sel_status   = addr_ok && (reg_sel == 3'd5);
    assign sel_prescale = addr_ok && (reg_sel == 3'd6);

    assign tx_full  = (tx_cnt_q == TX_FULL_CNT);
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == RX_FULL_CNT);
    assign rx_empty = (rx_cnt_q == '0);
    assign busy     = core_busy | cmd_start_q;

    // A full FIFO still accepts a push when a pop frees a slot in the same cycle
    assign tx_do_pop  = tx_pop & ~tx_empty;
    assign tx_do_push = wr_commit & sel_txdata & (~tx_full | tx_do_pop);
    assign rx_do_pop  = rd_commit & sel_rxdata & ~rx_empty;
    assign rx_do_push = rx_push & (~rx_full | rx_do_pop);
    assign ovf_set    = rx_push & rx_full & ~rx_do_pop;
    // START uses the EN being written, so EN and START may be set together
    assign fire = wr_commit & sel_ctrl & PWDATA[1] & PWDATA[0] & ~core_busy & (count_q != '0);

    // Next-state logic for registers, FIFO pointers and command block
    always_comb begin
        wait_cnt_d  = (access && !PREADY) ? wait_cnt_q + 3'd1 : 3'd0;
        en_d        = en_q;
        rw_d        = rw_q;
        irq_en_d    = irq_en_q;
        addr_d      = addr_q;
        count_d     = count_q;
        prescale_d  = prescale_q;
        if (wr_commit && sel_ctrl) begin
            en_d     = PWDATA[0];
            rw_d     = PWDATA[2];
            irq_en_d = PWDATA[3];
        end
        if (wr_commit && sel_addr)     addr_d     = PWDATA[6:0];
        if (wr_commit && sel_count)    count_d    = PWDATA;
        if (wr_commit && sel_prescale) prescale_d = PWDATA;
        // Clear-then-set ordering makes a same-cycle event win over W1C
        done_d = (done_q & ~(wr_commit & sel_status & PWDATA[5])) | core_done;
        nack_d = (nack_q & ~(wr_commit & sel_status & PWDATA[6])) | core_nack;
        ovf_d  = (ovf_q  & ~(wr_commit & sel_status & PWDATA[7])) | ovf_set;
        cmd_start_d = fire;
        cmd_rw_d    = fire ? PWDATA[2] : cmd_rw_q;
        cmd_addr_d  = fire ? addr_q    : cmd_addr_q;
        cmd_count_d = fire ? count_q   : cmd_count_q;
        tx_wr_ptr_d = tx_wr_ptr_q + TX_AW'(tx_do_push);
        tx_rd_ptr_d = tx_rd_ptr_q + TX_AW'(tx_do_pop);
        tx_cnt_d    = tx_cnt_q + (TX_AW+1)'(tx_do_push) - (TX_AW+1)'(tx_do_pop);
        rx_wr_ptr_d = rx_wr_ptr_q + RX_AW'(rx_do_push);
        rx_rd_ptr_d = rx_rd_ptr_q + RX_AW'(rx_do_pop);
        rx_cnt_d    = rx_cnt_q + (RX_AW+1)'(rx_do_push) - (RX_AW+1)'(rx_do_pop);
    end

    // State flops with asynchronous reset
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wait_cnt_q <= '0;  en_q <= 1'b0;  rw_q <= 1'b0;  irq_en_q <= 1'b0;
            addr_q <= '0;  count_q <= '0;  prescale_q <= PRESCALE_RST;
            done_q <= 1'b0;  nack_q <= 1'b0;  ovf_q <= 1'b0;
            cmd_start_q <= 1'b0;  cmd_rw_q <= 1'b0;  cmd_addr_q <= '0;  cmd_count_q <= '0;
            tx_wr_ptr_q <= '0;  tx_rd_ptr_q <= '0;  tx_cnt_q <= '0;
            rx_wr_ptr_q <= '0;  rx_rd_ptr_q <= '0;  rx_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;  en_q <= en_d;  rw_q <= rw_d;  irq_en_q <= irq_en_d;
            addr_q <= addr_d;  count_q <= count_d;  prescale_q <= prescale_d;
            done_q <= done_d;  nack_q <= nack_d;  ovf_q <= ovf_d;
            cmd_start_q <= cmd_start_d;  cmd_rw_q <= cmd_rw_d;
            cmd_addr_q <= cmd_addr_d;  cmd_count_q <= cmd_count_d;
            tx_wr_ptr_q <= tx_wr_ptr_d;  tx_rd_ptr_q <= tx_rd_ptr_d;  tx_cnt_q <= tx_cnt_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;  rx_rd_ptr_q <= rx_rd_ptr_d;  rx_cnt_q <= rx_cnt_d;
        end
    end

    // FIFO storage; contents need no reset because the counts gate visibility
    always_ff @(posedge PCLK) begin
        if (tx_do_push) tx_mem[tx_wr_ptr_q] <= PWDATA;
        if (rx_do_push) rx_mem[rx_wr_ptr_q] <= rx_data;
    end

    // Read data mux; unmapped addresses and write-only registers read 0
    always_comb begin
        rdata = '0;
        if (sel_ctrl)     rdata[3:0] = {irq_en_q, rw_q, 1'b0, en_q};
        if (sel_addr)     rdata[6:0] = addr_q;
        if (sel_count)    rdata      = count_q;
        if (sel_rxdata && !rx_empty) rdata = rx_mem[rx_rd_ptr_q];
        if (sel_status)   rdata[7:0] = {ovf_q, nack_q, done_q, busy,
                                        rx_empty, rx_full, tx_empty, tx_full};
        if (sel_prescale) rdata      = prescale_q;
    end

    assign PRDATA    = (PREADY && !PWRITE) ? rdata : '0;
    assign tx_data   = tx_mem[tx_rd_ptr_q];
    assign tx_valid  = ~tx_empty;
    assign cmd_start = cmd_start_q;
    assign cmd_rw    = cmd_rw_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_count = cmd_count_q;
    assign prescale  = prescale_q;

`ifdef I2C_APB_IRQ_EN
    logic irq_q, irq_d;
    assign irq_d = irq_en_d & (done_d | nack_d | ovf_d);
    // Interrupt flop follows the post-update sticky state
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) irq_q <= 1'b0;
        else        irq_q <= irq_d;
    end
    assign irq = irq_q;
`endif
endmodule

// File: tb/tb_i2c_apb_fifo_regs.sv
// Testbench for i2c_apb_fifo_regs (WAIT_STATES=2), scoreboard-based.
module tb_i2c_apb_fifo_regs;
    logic       PCLK = 1'b0, PRESET = 1'b1;
    logic       PSELx = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [7:0] PADDR = '0, PWDATA = '0;
    logic       PREADY;
    logic [7:0] PRDATA, tx_data, cmd_count, prescale, rx_data = '0;
    logic       tx_valid, tx_pop = 1'b0, rx_push = 1'b0;
    logic       cmd_start, cmd_rw;
    logic [6:0] cmd_addr;
    logic       core_busy = 1'b0, core_done = 1'b0, core_nack = 1'b0;
`ifdef I2C_APB_IRQ_EN
    logic       irq;
`endif

    int errors = 0;
    int checks = 0;
    int start_cnt = 0;
    logic [7:0] exp_q[$];

    i2c_apb_fifo_regs #(.WAIT_STATES(2)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSELx(PSELx), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(PREADY),
        .PRDATA(PRDATA), .tx_data(tx_data), .tx_valid(tx_valid), .tx_pop(tx_pop),
        .rx_data(rx_data), .rx_push(rx_push), .cmd_start(cmd_start), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_count(cmd_count), .prescale(prescale),
        .core_busy(core_busy), .core_done(core_done), .core_nack(core_nack)
`ifdef I2C_APB_IRQ_EN
        , .irq(irq)
`endif
    );

    // clock / reset
    always #5 PCLK = ~PCLK;
    always @(negedge PCLK) if (cmd_start === 1'b1) start_cnt++;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One APB transfer; side=1 pushes side_val into RX, side=2 pulses core_done,
    // both during the completing access cycle.
    task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                            input int side, input logic [7:0] side_val,
                            output logic [7:0] rdata, output int cycles);
        PSELx = 1'b1; PWRITE = wr; PADDR = addr; PWDATA = wdata; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1; #1;
        cycles = 1;
        while (PREADY !== 1'b1 && cycles < 20) begin
            @(posedge PCLK); #2;
            cycles++;
        end
        checks++;
        if (PREADY !== 1'b1) begin
            errors++;
            $display("FAIL apb_timeout addr=%h: PREADY=%b after %0d cycles, required 1", addr, PREADY, cycles);
        end
        rdata = PRDATA;
        if (side == 1) begin rx_data = side_val; rx_push = 1'b1; end
        else if (side == 2) core_done = 1'b1;
        @(posedge PCLK); #1;
        PSELx = 1'b0; PENABLE = 1'b0; rx_push = 1'b0; core_done = 1'b0;
    endtask

    task automatic apb_write(input logic [7:0] addr, input logic [7:0] data);
        logic [7:0] d; int c;
        apb_xfer(1'b1, addr, data, 0, 8'h00, d, c);
    endtask

    task automatic apb_read(input logic [7:0] addr, output logic [7:0] data);
        int c;
        apb_xfer(1'b0, addr, 8'h00, 0, 8'h00, data, c);
    endtask

    task automatic pulse_core(input int which);
        if (which == 0) core_done = 1'b1; else core_nack = 1'b1;
        @(posedge PCLK); #1;
        core_done = 1'b0; core_nack = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] addrs [8] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C};
        logic [7:0] exps  [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h32, 8'h00};
        logic [7:0] d;
        PRESET = 1'b1;
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b0;
        @(posedge PCLK); #1;
        checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL idle_pready: got %b want 0", PREADY); end
        checks++; if (cmd_start !== 1'b0 || cmd_count !== 8'h00) begin errors++;
            $display("FAIL reset_cmd: start=%b count=%h want 0/00", cmd_start, cmd_count); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        checks++; if (prescale !== 8'h32) begin errors++; $display("FAIL reset_prescale_out: got %h want 32", prescale); end
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(exps[i]);
            apb_read(addrs[i], d);
            checks++;
            if (d !== exp_q[0]) begin errors++;
                $display("FAIL reset_read addr=%h: got %h want %h", addrs[i], d, exp_q[0]); end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_wait_states();
        logic [7:0] d; int c;
        apb_xfer(1'b1, 8'h04, 8'h50, 0, 8'h00, d, c);
        checks++; if (c !== 3) begin errors++; $display("FAIL wait_write_cycles: got %0d want 3", c); end
        checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL pready_after: got %b want 0", PREADY); end
        apb_write(8'h1C, 8'h11);
        apb_write(8'h24, 8'h11);
        apb_xfer(1'b0, 8'h04, 8'h00, 0, 8'h00, d, c);
        checks++; if (c !== 3) begin errors++; $display("FAIL wait_read_cycles: got %0d want 3", c); end
        checks++; if (d !== 8'h50) begin errors++; $display("FAIL addr_readback: got %h want 50", d); end
    endtask

    task automatic test_tx_fifo();
        logic [7:0] d, e;
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(i));
            apb_write(8'h0C, 8'(i));
        end
        apb_write(8'h0C, 8'hFF);
        apb_read(8'h14, d);
        checks++; if (d !== 8'h09) begin errors++; $display("FAIL tx_full_status: got %h want 09", d); end
        apb_read(8'h0C, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL txdata_read: got %h want 00", d); end
        for (int i = 0; i < 16; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== e) begin errors++;
                $display("FAIL tx_order[%0d]: valid=%b data=%h want 1/%h", i, tx_valid, tx_data, e); end
            tx_pop = 1'b1; @(posedge PCLK); #1; tx_pop = 1'b0;
        end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_drained: valid=%b want 0", tx_valid); end
        tx_pop = 1'b1; @(posedge PCLK); #1; tx_pop = 1'b0;
        apb_read(8'h14, d);
        checks++; if (d !== 8'h0A) begin errors++; $display("FAIL tx_pop_empty: status %h want 0A", d); end
    endtask

    task automatic test_cmd();
        logic [7:0] d;
        apb_write(8'h08, 8'h03);
        start_cnt = 0;
        apb_write(8'h00, 8'h07);
        checks++;
        if (cmd_start !== 1'b1 || cmd_count !== 8'h03 || cmd_rw !== 1'b1 || cmd_addr !== 7'h50) begin
            errors++;
            $display("FAIL cmd_pulse: start=%b count=%h rw=%b addr=%h want 1/03/1/50",
                     cmd_start, cmd_count, cmd_rw, cmd_addr);
        end
        repeat (3) @(posedge PCLK); #1;
        checks++; if (start_cnt !== 1) begin errors++; $display("FAIL cmd_one_pulse: got %0d want 1", start_cnt); end
        apb_read(8'h00, d);
        checks++; if (d !== 8'h05) begin errors++; $display("FAIL ctrl_read: got %h want 05", d); end
        core_busy = 1'b1;
        apb_write(8'h00, 8'h07);
        apb_read(8'h14, d);
        checks++; if (d !== 8'h1A) begin errors++; $display("FAIL busy_status: got %h want 1A", d); end
        core_busy = 1'b0;
        apb_write(8'h08, 8'h00);
        apb_write(8'h00, 8'h07);
        apb_write(8'h08, 8'h05);
        apb_write(8'h00, 8'h06);
        repeat (2) @(posedge PCLK); #1;
        checks++; if (start_cnt !== 1) begin errors++; $display("FAIL start_dropped: pulses %0d want 1", start_cnt); end
        checks++; if (cmd_count !== 8'h03 || cmd_rw !== 1'b1) begin errors++;
            $display("FAIL cmd_held: count=%h rw=%b want 03/1", cmd_count, cmd_rw); end
        apb_write(8'h00, 8'h00);
    endtask

    task automatic test_rx_fifo();
        logic [7:0] d, v, e; int c;
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            v = 8'($urandom_range(0, 255));
            exp_q.push_back(v);
            rx_data = v; rx_push = 1'b1; @(posedge PCLK); #1; rx_push = 1'b0;
        end
        rx_data = 8'hAA; rx_push = 1'b1; @(posedge PCLK); #1; rx_push = 1'b0;
        apb_read(8'h14, d);
        checks++; if (d !== 8'h86) begin errors++; $display("FAIL rx_ovf_status: got %h want 86", d); end
        apb_write(8'h14, 8'h80);
        apb_read(8'h14, d);
        checks++; if (d !== 8'h06) begin errors++; $display("FAIL rx_ovf_clear: got %h want 06", d); end
        e = exp_q.pop_front();
        exp_q.push_back(8'h5A);
        apb_xfer(1'b0, 8'h10, 8'h00, 1, 8'h5A, d, c);
        checks++; if (d !== e) begin errors++; $display("FAIL rx_pushpop_data: got %h want %h", d, e); end
        apb_read(8'h14, d);
        checks++; if (d !== 8'h06) begin errors++; $display("FAIL rx_pushpop_full: status %h want 06", d); end
        for (int i = 0; i < 16; i++) begin
            apb_read(8'h10, d);
            e = exp_q.pop_front();
            checks++; if (d !== e) begin errors++; $display("FAIL rx_order[%0d]: got %h want %h", i, d, e); end
        end
        apb_read(8'h10, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rx_empty_read: got %h want 00", d); end
        apb_read(8'h14, d);
        checks++; if (d !== 8'h0A) begin errors++; $display("FAIL rx_empty_status: got %h want 0A", d); end
    endtask

    task automatic test_sticky();
        logic [7:0] d; int c;
        pulse_core(0);
        apb_read(8'h14, d);
        checks++; if (d !== 8'h2A) begin errors++; $display("FAIL done_set: got %h want 2A", d); end
        pulse_core(1);
        apb_read(8'h14, d);
        checks++; if (d !== 8'h6A) begin errors++; $display("FAIL nack_set: got %h want 6A", d); end
        apb_xfer(1'b1, 8'h14, 8'h20, 2, 8'h00, d, c);
        apb_read(8'h14, d);
        checks++; if (d !== 8'h6A) begin errors++; $display("FAIL set_wins: got %h want 6A", d); end
        apb_write(8'h14, 8'h20);
        apb_read(8'h14, d);
        checks++; if (d !== 8'h4A) begin errors++; $display("FAIL done_w1c: got %h want 4A", d); end
        apb_write(8'h14, 8'h40);
        apb_read(8'h14, d);
        checks++; if (d !== 8'h0A) begin errors++; $display("FAIL nack_w1c: got %h want 0A", d); end
    endtask

    task automatic test_irq();
        logic [7:0] d;
        apb_write(8'h00, 8'h08);
        apb_read(8'h00, d);
        checks++; if (d !== 8'h08) begin errors++; $display("FAIL irq_en_read: got %h want 08", d); end
`ifdef I2C_APB_IRQ_EN
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b want 0", irq); end
        pulse_core(1);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_nack: got %b want 1", irq); end
        apb_write(8'h14, 8'h40);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", irq); end
`endif
        apb_write(8'h00, 8'h00);
    endtask

    task automatic test_reset_mid();
        apb_write(8'h0C, 8'h77);
        apb_write(8'h08, 8'h02);
        apb_write(8'h00, 8'h01);
        apb_write(8'h00, 8'h03);
        #2 PRESET = 1'b1;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || cmd_start !== 1'b0 || cmd_count !== 8'h00 || prescale !== 8'h32) begin
            errors++;
            $display("FAIL reset_mid: valid=%b start=%b count=%h prescale=%h want 0/0/00/32",
                     tx_valid, cmd_start, cmd_count, prescale);
        end
        @(posedge PCLK); #1 PRESET = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wait_states();
        test_tx_fifo();
        test_cmd();
        test_rx_fifo();
        test_sticky();
        test_irq();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
